dht11_frame_checker: RTL
========================

// Module: dht11_frame_checker
// PURPOSE
//  Consumer stage directly downstream of the DHT11 bit parser. Accepts the captured 40-bit frame
//  {hum_int, hum_dec, tmp_int, tmp_dec, sum} (MSB first) on a one-cycle strobe.
//  Verifies the checksum and plausibility, holds the last good reading and counts bad frames.
//  Optionally converts the integer parts to BCD for the display stage.
// PARAMETERS
//  HUM_MAX  100  highest accepted hum_int (inclusive)
//  TMP_MAX  60   highest accepted tmp_int (inclusive)
//  ERR_W    8    width of err_cnt; the counter saturates at 2**ERR_W-1
// PORTS
//  clk          in   1      system clock (100 MHz)
//  rst          in   1      asynchronous, active-high reset
//  frame_valid  in   1      one-cycle strobe from the parser; frame is valid in the same cycle
//  frame        in   40     raw DHT11 frame
//  rdy          out  1      high only in IDLE; frames are accepted only while rdy=1
//  hum_int      out  8      last good humidity, integer part
//  hum_dec      out  8      last good humidity, decimal part
//  tmp_int      out  8      last good temperature, integer part
//  tmp_dec      out  8      last good temperature, decimal part
//  data_valid   out  1      one-cycle pulse when the held reading is updated
//  crc_err      out  1      one-cycle pulse: checksum mismatch, or an all-zero frame
//  rng_err      out  1      one-cycle pulse: checksum good but the value is out of range
//  err_cnt      out  ERR_W  saturating count of crc_err plus rng_err events
// BEHAVIOUR
//  - Reset: all registered outputs 0. State is IDLE, so rdy=1. rst asserted in any state aborts
//    immediately; the partial conversion is discarded.
//  - FSM: IDLE -> CHECK -> [CONV x8] -> DONE -> IDLE. Edge E0 samples frame_valid=1 in IDLE and
//    registers frame.
//  - CHECK (edge E1):
//    - sum8 = (b4+b3+b2+b1) mod 256, compared with b0. Carries are discarded; 8-bit wrap is legal.
//    - Priority 1: mismatch, or frame==0, gives crc_err high for 1 cycle after E1.
//    - Priority 2: hum_int>HUM_MAX or tmp_int>TMP_MAX gives rng_err high for 1 cycle after E1.
//    - On either error: err_cnt+1 (held at max), held outputs unchanged, return to IDLE.
//  - On a pass: go to CONV (macro defined) or DONE (macro undefined).
//  - DONE: on leaving DONE, load the four data outputs and pulse data_valid for 1 cycle.
//    Latency from E0 to data_valid high: 10 edges with the macro, 2 edges without it.
//  - frame_valid while rdy=0 is ignored: no capture, no error, no counting. A strobe in the same
//    cycle as the DONE->IDLE return is also ignored.
//  - crc_err, rng_err and data_valid are mutually exclusive, and at most one fires per frame.
// CONFIGURATION
//  - DHT11_BCD_EN defined:
//    - Adds outputs hum_bcd[11:0] and tmp_bcd[11:0] (3 BCD digits each).
//    - CONV runs 8 double-dabble shift cycles (E2..E9); the BCD outputs load together with
//      data_valid; reset value is 0.
//  - DHT11_BCD_EN undefined: no BCD ports, no CONV state; CHECK passes directly to DONE.
// STRUCTURE
//  - dht11_pkg:
//    - typedef struct packed dht11_frame_t {hum_int, hum_dec, tmp_int, tmp_dec, sum}
//    - typedef enum chk_state_t {IDLE, CHECK, CONV, DONE}
//    - localparam FRAME_W=40, CONV_STEPS=8
//  - Sub-module bin2bcd8: serial double-dabble, 8-bit binary to 12-bit BCD, start/done handshake.
//    Instantiated twice (humidity and temperature), present only under DHT11_BCD_EN.
// TESTING
//  1. Good frame: frame=40'h2800190041 ->
//     - data_valid pulse at E10 (E2 without the macro)
//     - hum_int=40, tmp_int=25, hum_bcd=12'h040, tmp_bcd=12'h025
//     - err_cnt=0
//  2. Bad checksum: frame=40'h2800190042 after scenario 1 ->
//     - crc_err pulse at E1; outputs still hold 40/25; err_cnt=1
//  3. Checksum wrap at the range limits: frame=40'h5A633C635C (sum 348 mod 256 = 0x5C) ->
//     - data_valid; hum_int=90, tmp_int=60, tmp_bcd=12'h060
//  4. Range error and all-zero frame:
//     - 40'h6500140079 -> rng_err
//     - 40'h0 -> crc_err
//     - err_cnt +2; outputs unchanged
//  5. Busy and reset:
//     - frame_valid re-pulsed at E3 -> ignored, exactly one data_valid
//     - rst pulsed at E5 of another frame -> all outputs 0, rdy=1 within 1 cycle,
//       no data_valid for that frame
//  6. Saturation: 260 consecutive bad-checksum frames -> err_cnt=255 and stays at 255.

Source files
------------

// File: rtl/dht11_frame_checker_pkg.sv
// Shared types and constants for the DHT11 frame checker slice.
// DHT11_BCD_EN (when defined) enables the BCD conversion path in the top.
package dht11_pkg;

    localparam int FRAME_W    = 40;
    localparam int CONV_STEPS = 8;

    typedef struct packed {
        logic [7:0] hum_int;
        logic [7:0] hum_dec;
        logic [7:0] tmp_int;
        logic [7:0] tmp_dec;
        logic [7:0] sum;
    } dht11_frame_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        CONV  = 2'd2,
        DONE  = 2'd3
    } chk_state_t;

    // Checksum over the four data bytes; carries out of bit 7 are dropped on purpose
    function automatic logic [7:0] frame_sum8(input dht11_frame_t f);
        return f.hum_int + f.hum_dec + f.tmp_int + f.tmp_dec;
    endfunction

endpackage

// File: rtl/dht11_frame_checker_bin2bcd8.sv
// Serial double-dabble converter: 8-bit binary to 3 BCD digits in CONV_STEPS cycles.
// Only built when DHT11_BCD_EN is defined.
`ifdef DHT11_BCD_EN
module bin2bcd8
    import dht11_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic [11:0] bcd,
    output logic        done
);

    logic [7:0]  bin_q, bin_d;
    logic [11:0] bcd_q, bcd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [11:0] adj;

    // Add-3 correction on every digit >= 5, then shift one binary bit into the BCD register
    always_comb begin
        bin_d = bin_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        adj   = bcd_q;
        for (int i = 0; i < 3; i++) begin
            adj[i*4 +: 4] = bcd_q[i*4 +: 4] + ((bcd_q[i*4 +: 4] >= 4'd5) ? 4'd3 : 4'd0);
        end
        if (start) begin
            bin_d = bin;
            bcd_d = '0;
            cnt_d = 4'(CONV_STEPS);
        end else if (cnt_q != 4'd0) begin
            {bcd_d, bin_d} = {adj, bin_q} << 1;
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Conversion registers; reset discards any partial result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
        end
    end

    assign bcd  = bcd_q;
    assign done = (cnt_q == 4'd1);

endmodule
`endif

// File: rtl/dht11_frame_checker.sv
// DHT11 frame checker: validates checksum and range, holds the last good reading,
// counts bad frames. Define DHT11_BCD_EN to add BCD outputs and the CONV phase.
module dht11_frame_checker
    import dht11_pkg::*;
#(
    parameter int HUM_MAX = 100,
    parameter int TMP_MAX = 60,
    parameter int ERR_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_valid,
    input  logic [FRAME_W-1:0] frame,
    output logic               rdy,
    output logic [7:0]         hum_int,
    output logic [7:0]         hum_dec,
    output logic [7:0]         tmp_int,
    output logic [7:0]         tmp_dec,
    output logic               data_valid,
    output logic               crc_err,
    output logic               rng_err,
`ifdef DHT11_BCD_EN
    output logic [11:0]        hum_bcd,
    output logic [11:0]        tmp_bcd,
`endif
    output logic [ERR_W-1:0]   err_cnt
);

    localparam logic [7:0] HUM_LIM = 8'(HUM_MAX);
    localparam logic [7:0] TMP_LIM = 8'(TMP_MAX);

    chk_state_t   state_q, state_d;
    dht11_frame_t frame_q, frame_d;
    logic         rdy_q, rdy_d;
    logic [7:0]   hum_int_q, hum_int_d, hum_dec_q, hum_dec_d;
    logic [7:0]   tmp_int_q, tmp_int_d, tmp_dec_q, tmp_dec_d;
    logic         data_valid_q, data_valid_d;
    logic         crc_err_q, crc_err_d;
    logic         rng_err_q, rng_err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic         bcd_start;

`ifdef DHT11_BCD_EN
    logic [11:0] hum_bcd_q, hum_bcd_d, tmp_bcd_q, tmp_bcd_d;
    logic [11:0] hum_bcd_w, tmp_bcd_w;
    logic        hum_done, tmp_done;

    bin2bcd8 u_hum_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (bcd_start),
        .bin   (frame_q.hum_int),
        .bcd   (hum_bcd_w),
        .done  (hum_done)
    );

    bin2bcd8 u_tmp_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (bcd_start),
        .bin   (frame_q.tmp_int),
        .bcd   (tmp_bcd_w),
        .done  (tmp_done)
    );
`endif

    // Next-state logic: capture in IDLE, judge in CHECK, publish on leaving DONE
    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        hum_int_d    = hum_int_q;
        hum_dec_d    = hum_dec_q;
        tmp_int_d    = tmp_int_q;
        tmp_dec_d    = tmp_dec_q;
        err_cnt_d    = err_cnt_q;
        data_valid_d = 1'b0;
        crc_err_d    = 1'b0;
        rng_err_d    = 1'b0;
        bcd_start    = 1'b0;
`ifdef DHT11_BCD_EN
        hum_bcd_d    = hum_bcd_q;
        tmp_bcd_d    = tmp_bcd_q;
`endif
        case (state_q)
            IDLE: begin
                if (frame_valid) begin
                    frame_d = dht11_frame_t'(frame);
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if ((frame_sum8(frame_q) != frame_q.sum) || (frame_q == '0)) begin
                    crc_err_d = 1'b1;
                    state_d   = IDLE;
                    if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                end else if ((frame_q.hum_int > HUM_LIM) || (frame_q.tmp_int > TMP_LIM)) begin
                    rng_err_d = 1'b1;
                    state_d   = IDLE;
                    if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                end else begin
`ifdef DHT11_BCD_EN
                    bcd_start = 1'b1;
                    state_d   = CONV;
`else
                    state_d   = DONE;
`endif
                end
            end
            CONV: begin
`ifdef DHT11_BCD_EN
                if (hum_done && tmp_done) state_d = DONE;
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                hum_int_d    = frame_q.hum_int;
                hum_dec_d    = frame_q.hum_dec;
                tmp_int_d    = frame_q.tmp_int;
                tmp_dec_d    = frame_q.tmp_dec;
                data_valid_d = 1'b1;
                state_d      = IDLE;
`ifdef DHT11_BCD_EN
                hum_bcd_d    = hum_bcd_w;
                tmp_bcd_d    = tmp_bcd_w;
`endif
            end
            default: state_d = IDLE;
        endcase
        rdy_d = (state_d == IDLE);
    end

    // State and registered outputs; reset aborts any frame in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            frame_q      <= '0;
            rdy_q        <= 1'b1;
            hum_int_q    <= '0;
            hum_dec_q    <= '0;
            tmp_int_q    <= '0;
            tmp_dec_q    <= '0;
            data_valid_q <= 1'b0;
            crc_err_q    <= 1'b0;
            rng_err_q    <= 1'b0;
            err_cnt_q    <= '0;
`ifdef DHT11_BCD_EN
            hum_bcd_q    <= '0;
            tmp_bcd_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            rdy_q        <= rdy_d;
            hum_int_q    <= hum_int_d;
            hum_dec_q    <= hum_dec_d;
            tmp_int_q    <= tmp_int_d;
            tmp_dec_q    <= tmp_dec_d;
            data_valid_q <= data_valid_d;
            crc_err_q    <= crc_err_d;
            rng_err_q    <= rng_err_d;
            err_cnt_q    <= err_cnt_d;
`ifdef DHT11_BCD_EN
            hum_bcd_q    <= hum_bcd_d;
            tmp_bcd_q    <= tmp_bcd_d;
`endif
        end
    end

    assign rdy        = rdy_q;
    assign hum_int    = hum_int_q;
    assign hum_dec    = hum_dec_q;
    assign tmp_int    = tmp_int_q;
    assign tmp_dec    = tmp_dec_q;
    assign data_valid = data_valid_q;
    assign crc_err    = crc_err_q;
    assign rng_err    = rng_err_q;
    assign err_cnt    = err_cnt_q;
`ifdef DHT11_BCD_EN
    assign hum_bcd    = hum_bcd_q;
    assign tmp_bcd    = tmp_bcd_q;
`endif

endmodule
